// File: rtl/core_traffic_gen_pkg.sv
// Shared types and constants for the per-core LFSR traffic generator.
// Provides bus widths, the generator state enum, the LFSR polynomial and the
// registered request payload carried on the cpu_* port.
package core_traffic_gen_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned CACHELINE_SIZE = 256;
  localparam int unsigned PAT_W          = 32;
  localparam int unsigned LFSR_W         = 32;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } gen_state_t;

  typedef struct packed {
    logic                      we;
    logic [XLEN-1:0]           addr;
    logic [CACHELINE_SIZE-1:0] wdata;
  } cpu_op_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/core_traffic_gen_lfsr.sv
// gen_lfsr: 32-bit Galois LFSR with synchronous seed load and step enable.
// Ports: clk, rst (async, active-high), load/seed (zero seed becomes 1),
//        step (advance one position), state (current LFSR value).
module gen_lfsr
  import core_traffic_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  // All-zero is the lock-up state of the LFSR, so it is never loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LFSR_W'(1);
    end else if (load) begin
      state <= (seed == '0) ? LFSR_W'(1) : seed;
    end else if (step) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/core_traffic_gen.sv
// core_traffic_gen: LFSR-driven read/write request generator for one core's
// L1 cpu_* port, with shadow-copy checking of read data in private windows.
// Ports: clk, rst (async, active-high), start (run pulse),
//        cpu_ready/cpu_resp/cpu_rdata (from cache),
//        cpu_req/cpu_we/cpu_addr/cpu_wdata (to cache),
//        busy, done, error (sticky), op_count, mismatch_count.
module core_traffic_gen
  import core_traffic_gen_pkg::*;
#(
  parameter int unsigned     ID         = 0,
  parameter int unsigned     NUM_OPS    = 256,
  parameter int unsigned     ADDR_LINES = 16,
  parameter bit              PRIVATE    = 1'b1,
  parameter logic [XLEN-1:0] ADDR_BASE  = '0,
  parameter int unsigned     WR_PCT     = 50,
  parameter logic [31:0]     SEED       = 32'h1,
  parameter int unsigned     TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cpu_ready,
  input  logic                      cpu_resp,
  input  logic [CACHELINE_SIZE-1:0] cpu_rdata,
  output logic                      cpu_req,
  output logic                      cpu_we,
  output logic [XLEN-1:0]           cpu_addr,
  output logic [CACHELINE_SIZE-1:0] cpu_wdata,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [31:0]               op_count,
  output logic [31:0]               mismatch_count
);

  localparam int unsigned     IDX_W      = $clog2(ADDR_LINES);
  localparam int unsigned     LINE_BYTES = CACHELINE_SIZE / 8;
  localparam int unsigned     PAT_REP    = CACHELINE_SIZE / PAT_W;
  localparam logic [XLEN-1:0] WIN_BASE   = PRIVATE ?
                                           ADDR_BASE + XLEN'(ID * ADDR_LINES * LINE_BYTES) :
                                           ADDR_BASE;
  localparam logic [31:0]     TO_LAST    = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);
  localparam logic [31:0]     OPS_TARGET = 32'(NUM_OPS);
  localparam logic [31:0]     WR_THRESH  = 32'(WR_PCT);
  localparam logic [7:0]      ID8        = 8'(ID);

  gen_state_t state_q, state_d;
  logic       busy_d, done_d, req_d;
  logic       busy_q, done_q, req_q;

  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt;
  logic              lfsr_unused_c;
  logic              start_ok, step_en, resp_ok, chk_c, timeout_c, mismatch_c;
  logic              is_wr_c;
  logic [31:0]       pct_c;
  logic [IDX_W-1:0]  idx_c, idx_q;
  logic [XLEN-1:0]   addr_c;
  logic [PAT_W-1:0]  pat_c;

  cpu_op_t                   op_q;
  logic [31:0]               op_cnt_q, mm_cnt_q, tcnt_q, ops_inc;
  logic                      error_q;
  logic [ADDR_LINES-1:0]     vld_q;
  logic [CACHELINE_SIZE-1:0] shadow_q [ADDR_LINES];
  logic [CACHELINE_SIZE-1:0] rdata_q;

  gen_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_ok),
    .seed  (SEED ^ 32'(ID)),
    .step  (step_en),
    .state (lfsr_q)
  );

  // Op decode works on the value the LFSR will hold after this step.
  assign lfsr_nxt      = lfsr_step(lfsr_q);
  assign lfsr_unused_c = ^lfsr_nxt;
  assign pct_c         = 32'(lfsr_nxt[6:0]) % 32'd100;
  assign is_wr_c       = pct_c < WR_THRESH;
  assign idx_c         = lfsr_nxt[16 +: IDX_W];
  assign addr_c        = WIN_BASE + XLEN'(idx_c) * XLEN'(LINE_BYTES);
  assign pat_c         = {ID8, op_cnt_q[23:0]};

  assign start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign step_en    = (state_q == ST_ISSUE) && cpu_ready;
  assign resp_ok    = (state_q == ST_WAIT) && cpu_resp;
  assign chk_c      = PRIVATE && !op_q.we && vld_q[idx_q];
  assign timeout_c  = (state_q == ST_WAIT) && !cpu_resp && (tcnt_q >= TO_LAST);
  assign mismatch_c = rdata_q != shadow_q[idx_q];
  assign ops_inc    = (op_cnt_q == '1) ? op_cnt_q : op_cnt_q + 32'd1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (OPS_TARGET == '0) ? ST_DONE : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (cpu_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cpu_resp) begin
          if (chk_c)                        state_d = ST_CHECK;
          else if (ops_inc >= OPS_TARGET)   state_d = ST_DONE;
          else                              state_d = ST_ISSUE;
        end else if (timeout_c) begin
          state_d = ST_DONE;
        end
      end
      ST_CHECK: begin
        state_d = (op_cnt_q >= OPS_TARGET) ? ST_DONE : ST_ISSUE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    req_d  = 1'b0;
    unique case (state_d)
      ST_ISSUE, ST_CHECK: busy_d = 1'b1;
      ST_WAIT: begin
        busy_d = 1'b1;
        req_d  = 1'b1;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath: request payload, counters, shadow valid bits, captured read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      op_q     <= '0;
      idx_q    <= '0;
      op_cnt_q <= '0;
      mm_cnt_q <= '0;
      tcnt_q   <= '0;
      error_q  <= 1'b0;
      vld_q    <= '0;
      rdata_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      req_q  <= req_d;
      if (start_ok) begin
        op_cnt_q <= '0;
        mm_cnt_q <= '0;
        error_q  <= 1'b0;
        vld_q    <= '0;
      end
      if (step_en) begin
        op_q.we    <= is_wr_c;
        op_q.addr  <= addr_c;
        op_q.wdata <= is_wr_c ? {PAT_REP{pat_c}} : '0;
        idx_q      <= idx_c;
        tcnt_q     <= '0;
      end
      if (resp_ok) begin
        op_cnt_q <= ops_inc;
        if (op_q.we) vld_q[idx_q] <= 1'b1;
        if (chk_c)   rdata_q      <= cpu_rdata;
      end else if (state_q == ST_WAIT) begin
        tcnt_q <= tcnt_q + 32'd1;
        if (timeout_c) error_q <= 1'b1;
      end
      if ((state_q == ST_CHECK) && mismatch_c) begin
        if (mm_cnt_q != '1) mm_cnt_q <= mm_cnt_q + 32'd1;
        error_q <= 1'b1;
      end
    end
  end

  // Shadow line store; only lines with a set valid bit are ever compared.
  always_ff @(posedge clk) begin
    if (resp_ok && op_q.we) shadow_q[idx_q] <= op_q.wdata;
  end

  assign cpu_req        = req_q;
  assign cpu_we         = op_q.we;
  assign cpu_addr       = op_q.addr;
  assign cpu_wdata      = op_q.wdata;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign op_count       = op_cnt_q;
  assign mismatch_count = mm_cnt_q;

endmodule

// File: tb/tb_core_traffic_gen.sv
// Testbench for core_traffic_gen: random-latency memory-model cache, spec-level
// op-sequence model, plus a write-only ideal-cache instance.
module tb_core_traffic_gen;

  localparam int unsigned T_ID    = 2;
  localparam int unsigned T_OPS   = 64;
  localparam int unsigned T_LINES = 4;
  localparam int unsigned T_WR    = 50;
  localparam int unsigned T_TO    = 16;
  localparam logic [31:0] T_SEED  = 32'h1234_5678;
  localparam logic [31:0] T_TAPS  = 32'h8020_0003;
  localparam logic [31:0] T_WIN   = 32'(T_ID * T_LINES * 32);

  logic         clk, rst, start, cpu_ready, cpu_resp;
  logic [255:0] cpu_rdata, cpu_wdata;
  logic         cpu_req, cpu_we, busy, done, error;
  logic [31:0]  cpu_addr, op_count, mismatch_count;

  logic         start_w, resp_w, req_w, we_w, busy_w, done_w, error_w;
  logic [255:0] wdata_w;
  logic [31:0]  addr_w, op_count_w, mm_w;

  int vectors = 0;
  int errors  = 0;

  logic [31:0]  exp_addr  [T_OPS];
  bit           exp_we    [T_OPS];
  logic [255:0] exp_wdata [T_OPS];
  bit           exp_chk   [T_OPS];
  logic [31:0]  first_addr[T_OPS];
  int           exp_mm;

  logic [255:0] mem [64];
  int  cyc = 0, resp_cyc = 0, opi = 0, req_hi = 0, wait_cnt = 0, wr_seen = 0;
  bit  force_ready = 0, flip_mode = 0, no_resp = 0, timing_on = 0;
  bit  rec_addr = 0, cmp_addr = 0, req_prev = 0, resp_prev = 0, req_prev_w = 0;

  core_traffic_gen #(
    .ID(T_ID), .NUM_OPS(T_OPS), .ADDR_LINES(T_LINES), .PRIVATE(1'b1),
    .ADDR_BASE(32'h0), .WR_PCT(T_WR), .SEED(T_SEED), .TIMEOUT(T_TO)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .cpu_ready(cpu_ready),
    .cpu_resp(cpu_resp), .cpu_rdata(cpu_rdata), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .busy(busy), .done(done), .error(error), .op_count(op_count),
    .mismatch_count(mismatch_count)
  );

  core_traffic_gen #(
    .ID(1), .NUM_OPS(8), .ADDR_LINES(4), .PRIVATE(1'b1),
    .ADDR_BASE(32'h0), .WR_PCT(100), .SEED(32'h1), .TIMEOUT(1024)
  ) u_wr (
    .clk(clk), .rst(rst), .start(start_w), .cpu_ready(1'b1),
    .cpu_resp(resp_w), .cpu_rdata(256'h0), .cpu_req(req_w),
    .cpu_we(we_w), .cpu_addr(addr_w), .cpu_wdata(wdata_w),
    .busy(busy_w), .done(done_w), .error(error_w), .op_count(op_count_w),
    .mismatch_count(mm_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
    end
  endtask

  // Predicts the op sequence of one run from the seed, decode rules and shadow validity.
  task automatic model(input bit flip);
    logic [31:0] s;
    int          idx;
    bit          vld [T_LINES];
    s = T_SEED ^ T_ID;
    if (s == 0) s = 1;
    exp_mm = 0;
    foreach (vld[k]) vld[k] = 1'b0;
    for (int i = 0; i < int'(T_OPS); i++) begin
      s = (s % 2 == 1) ? ((s >> 1) ^ T_TAPS) : (s >> 1);
      exp_we[i]    = ((s % 128) % 100) < T_WR;
      idx          = int'((s >> 16) % T_LINES);
      exp_addr[i]  = T_WIN + 32'(idx * 32);
      exp_wdata[i] = exp_we[i] ? {8{8'(T_ID), 24'(i)}} : 256'h0;
      exp_chk[i]   = !exp_we[i] && vld[idx];
      if (exp_we[i]) vld[idx] = 1'b1;
      else if (exp_chk[i] && flip && idx == 2) exp_mm++;
    end
  endtask

  // Cache model for the main instance plus request scoreboard.
  initial begin
    logic [5:0] line;
    cpu_ready = 1'b0; cpu_resp = 1'b0; cpu_rdata = '0;
    for (int i = 0; i < 64; i++) mem[i] = {8{$urandom}};
    forever begin
      @(negedge clk);
      cyc++;
      resp_prev = cpu_resp;
      cpu_resp  = 1'b0;
      cpu_ready = force_ready || ($urandom_range(0, 2) != 0);
      if (resp_prev) chk("req_drop", 256'(cpu_req), 256'(0));
      if (cpu_req && !req_prev) begin
        if (opi < int'(T_OPS)) begin
          chk("addr",  256'(cpu_addr), 256'(exp_addr[opi]));
          chk("we",    256'(cpu_we),   256'(exp_we[opi]));
          chk("wdata", cpu_wdata,      exp_wdata[opi]);
          if (timing_on && opi > 0)
            chk("resp_to_req", 256'(cyc - resp_cyc), exp_chk[opi-1] ? 256'(3) : 256'(2));
          if (rec_addr) first_addr[opi] = cpu_addr;
          else if (cmp_addr) chk("repeat_addr", 256'(cpu_addr), 256'(first_addr[opi]));
        end
        opi++;
      end
      if (cpu_req) req_hi++;
      if (cpu_req && !no_resp) begin
        if (wait_cnt == 0) begin
          cpu_resp = 1'b1;
          resp_cyc = cyc;
          line     = cpu_addr[10:5];
          if (cpu_we) mem[line] = cpu_wdata;
          else begin
            cpu_rdata = mem[line];
            if (flip_mode && cpu_addr == T_WIN + 32'd64) cpu_rdata[0] = ~cpu_rdata[0];
          end
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
      req_prev = cpu_req;
    end
  end

  // Ideal single-cycle cache for the write-only instance.
  initial begin
    resp_w = 1'b0;
    forever begin
      @(negedge clk);
      if (req_w && !req_prev_w) begin
        chk("wr_we", 256'(we_w), 256'(1));
        chk("wr_range", 256'(addr_w >= 32'd128 && addr_w <= 32'd255), 256'(1));
        chk("wr_align", 256'(addr_w[4:0]), 256'(0));
        chk("wr_data", wdata_w, {8{8'd1, 24'(wr_seen)}});
        wr_seen++;
      end
      resp_w     = req_w && !resp_w;
      req_prev_w = req_w;
    end
  end

  task automatic run(input bit flip);
    int lat, n;
    model(flip);
    flip_mode = flip;
    opi = 0;
    @(negedge clk);
    start = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end while (!cpu_req && !done && lat < 64);
    if (force_ready) chk("start_to_req", 256'(lat), 256'(2));
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("run_done", 256'(done), 256'(1));
  endtask

  task automatic end_checks(input int ops, input int mm, input bit err);
    chk("op_count", 256'(op_count), 256'(ops));
    chk("mismatch_count", 256'(mismatch_count), 256'(mm));
    chk("error", 256'(error), 256'(err));
    chk("busy_end", 256'(busy), 256'(0));
    chk("req_end", 256'(cpu_req), 256'(0));
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; start_w = 1'b0;
    #12;
    chk("rst_req", 256'(cpu_req), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_addr", 256'(cpu_addr), 256'(0));
    chk("rst_opcnt", 256'(op_count), 256'(0));
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 256'(busy), 256'(0));
    chk("idle_done", 256'(done), 256'(0));

    force_ready = 1; timing_on = 1; rec_addr = 1;
    run(1'b0);
    end_checks(T_OPS, 0, 1'b0);
    chk("ops_issued", 256'(opi), 256'(T_OPS));

    force_ready = 0; timing_on = 0; rec_addr = 0; cmp_addr = 1;
    run(1'b0);
    end_checks(T_OPS, 0, 1'b0);

    run(1'b1);
    end_checks(T_OPS, exp_mm, exp_mm != 0);

    no_resp = 1; req_hi = 0;
    run(1'b0);
    chk("timeout_req_cycles", 256'(req_hi), 256'(T_TO));
    end_checks(0, 0, 1'b1);
    no_resp = 0;

    // Reset mid-transaction, then a fresh run must replay the same sequence.
    model(1'b0);
    opi = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(cpu_req && opi >= 5) && n < 5000);
    chk("pre_rst_req", 256'(cpu_req), 256'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", 256'(cpu_req), 256'(0));
    chk("async_rst_busy", 256'(busy), 256'(0));
    chk("async_rst_addr", 256'(cpu_addr), 256'(0));
    chk("async_rst_we", 256'(cpu_we), 256'(0));
    chk("async_rst_opcnt", 256'(op_count), 256'(0));
    @(negedge clk); rst = 1'b0;
    run(1'b0);
    end_checks(T_OPS, 0, 1'b0);

    @(negedge clk); start_w = 1'b1;
    @(negedge clk); start_w = 1'b0;
    n = 0;
    while (!done_w && n < 2000) begin @(negedge clk); n++; end
    chk("wr_done", 256'(done_w), 256'(1));
    chk("wr_opcnt", 256'(op_count_w), 256'(8));
    chk("wr_error", 256'(error_w), 256'(0));
    chk("wr_seen", 256'(wr_seen), 256'(8));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/core_traffic_gen.md
# core_traffic_gen

Synthesizable, parametrised request generator for one core port of the MESI cache system. It replaces file-driven stimulus with LFSR-generated read/write traffic over a configurable line-aligned address window, drives the cpu_* handshake to its private L1 cache, and self-checks read data against a local shadow copy when the window is private to the core. One instance per core sits between the testbench top and each L1 cache.

## Interface
- ID, 0: core index; mixed into LFSR seed and write-data pattern.
- NUM_OPS, 256: operations issued per start.
- ADDR_LINES, 16: lines in the window; power of two, ≥2.
- PRIVATE, 1: 1 = window at ADDR_BASE + ID·ADDR_LINES lines, data checked; 0 = window at ADDR_BASE shared by all cores, no checking.
- ADDR_BASE, 0: byte base address; line-aligned.
- WR_PCT, 50: write probability in percent, 0–100.
- SEED, 32'h1: LFSR seed base.
- TIMEOUT, 1024: max cycles waiting for cpu_resp.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE.
- cpu_ready  in  1  cache can accept a request.
- cpu_resp  in  1  one-cycle completion of current request.
- cpu_rdata  in  CACHELINE_SIZE  read line, valid with cpu_resp.
- cpu_req  out  1  request valid.
- cpu_we  out  1  1 = write.
- cpu_addr  out  XLEN  line-aligned byte address.
- cpu_wdata  out  CACHELINE_SIZE  write line; 0 on reads.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- error  out  1  sticky: mismatch or timeout.
- op_count  out  32  completed operations.
- mismatch_count  out  32  failed read compares.

## Operation
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE + start: clear op_count, mismatch_count, error, shadow valid bits; load LFSR with (SEED ^ ID), forced to 1 if zero; → ISSUE.
- ISSUE: when cpu_ready, step LFSR once, register op → WAIT. Without cpu_ready, hold.
- Op decode from the stepped value L: write iff (L[6:0] % 100) < WR_PCT; line index = L[16 +: log2(ADDR_LINES)]; cpu_addr = window base + index·(CACHELINE_SIZE/8).
- Write data: 32-bit word {ID[7:0], op_count[23:0]} replicated across the line.
- LFSR: 32-bit Galois, taps 32'h80200003.
- WAIT: cpu_req = 1 with cpu_we/addr/wdata stable until cpu_resp. On cpu_resp: write → store wdata in shadow[index], set valid; read with PRIVATE and valid → register cpu_rdata → CHECK; otherwise no check. op_count++. Next state CHECK (checked read), DONE (op_count reaches NUM_OPS), or ISSUE.
- CHECK: compare registered rdata to shadow[index]; on mismatch mismatch_count++, error = 1. Then DONE or ISSUE by the same count rule.
- Timeout: counter clears on entering WAIT and increments each WAIT cycle; at TIMEOUT without cpu_resp set error, drop cpu_req → DONE; op_count not incremented.
- cpu_resp outside WAIT is ignored.
- Counters saturate at 2^32−1.

## Timing
- Reset (async): state IDLE; every output 0; LFSR = 1; shadow valid bits cleared. Asserting rst mid-transaction drops cpu_req in the same cycle, not at the next edge.
- All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- start → first cpu_req: 2 cycles if cpu_ready is high.
- cpu_resp → next cpu_req: 2 cycles for write or unchecked read, 3 for checked read (ready high).
- cpu_req deasserts the cycle after cpu_resp.
- done and busy change in the same cycle; busy = ISSUE | WAIT | CHECK.
- NUM_OPS = 0: start → DONE directly, no request issued.

## Structure
- In types: add gen_state_t (the five states), LFSR_TAPS, and the write-pattern word width constant. Reuse XLEN and CACHELINE_SIZE.
- One sub-module, gen_lfsr (seed load, step enable, 32-bit state out).
- Shadow storage is flops (ADDR_LINES × CACHELINE_SIZE) with a per-line valid bit, indexed by the registered index.

## Test plan
- WR_PCT=100, NUM_OPS=8, ADDR_LINES=4, ID=1, ADDR_BASE=0, CACHELINE_SIZE=256, ideal cache → 8 writes, all addresses in [128, 255] and 32-byte aligned, op_count=8, done=1, error=0.
- WR_PCT=0, NUM_OPS=16 → 16 reads, cpu_wdata=0 throughout, mismatch_count=0 (no valid shadow).
- WR_PCT=50, NUM_OPS=256, memory-model cache → mismatch_count=0, error=0. Repeat start → identical address sequence.
- Same run with cache flipping bit 0 of every read of line 2 → mismatch_count equals checked reads of line 2, error=1.
- TIMEOUT=16, cache never responds → cpu_req high 16 cycles, then error=1, done=1, op_count=0.
- rst asserted mid-WAIT → cpu_req and all outputs 0 before the next clock edge; fresh start after release reproduces the first-run sequence.
